code_conv_sched: RTL and testbench

Two-requester scheduler for the shared 4-bit code-conversion unit, which performs BCD 8421 to excess-3 and 4-bit binary to Gray conversion.

- Arbitrates between requester A and requester B using round-robin.
- Performs one conversion per grant and registers the result.
- Presents the result on a valid/ready response port.
- Keeps per-requester completion counters and an error counter.
- Sits between the front-end requesters and the response consumer in the code-conversion subsystem.

---
 rtl/code_conv_sched.sv | 115 +++++++++++
 tb/tb_code_conv_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/code_conv_sched.sv
// Round-robin scheduler for two requesters sharing one BCD->excess-3 / binary->Gray
// converter, with a single registered valid/ready response slot and statistics counters.
module code_conv_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_a,
  output logic             req_ready_a,
  input  logic [3:0]       req_data_a,
  input  logic             req_mode_a,
  input  logic             req_valid_b,
  output logic             req_ready_b,
  input  logic [3:0]       req_data_b,
  input  logic             req_mode_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_data,
  output logic             rsp_id,
  output logic             rsp_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] done_cnt_a,
  output logic [CNT_W-1:0] done_cnt_b,
  output logic [CNT_W-1:0] err_cnt
);

  // Handshake: a request transfers on a cycle where req_valid_x and req_ready_x are
  // both high; the response transfers on a cycle where rsp_valid and rsp_ready are both high.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state, state_nxt;
  logic       prio;        // 0 = A holds priority, 1 = B
  logic       grant_a, grant_b;
  logic       accept;
  logic [3:0] sel_data;
  logic       sel_mode;
  logic [3:0] conv_data;
  logic       conv_err;

  always_comb begin
    state_nxt = state;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
        grant_a = req_valid_a & (~req_valid_b | ~prio);
        grant_b = req_valid_b & (~req_valid_a | prio);
        if (grant_a | grant_b) state_nxt = BUSY;
      end
      BUSY: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready_a = (state == IDLE) & grant_a;
  assign req_ready_b = (state == IDLE) & grant_b;
  assign accept      = req_ready_a | req_ready_b;
  assign rsp_valid   = (state == BUSY);

  assign sel_data = grant_b ? req_data_b : req_data_a;
  assign sel_mode = grant_b ? req_mode_b : req_mode_a;

  always_comb begin
    conv_data = 4'b0000;
    conv_err  = 1'b0;
    if (sel_mode) begin
      conv_data = sel_data ^ (sel_data >> 1);
    end else if (sel_data <= 4'd9) begin
      conv_data = sel_data + 4'd3;
    end else begin
      conv_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      prio     <= 1'b0;
      rsp_data <= 4'b0000;
      rsp_id   <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_data <= conv_data;
        rsp_id   <= grant_b;
        rsp_err  <= conv_err;
        prio     <= ~grant_b;
      end
    end
  end

  // Counters saturate; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_a <= '0;
      done_cnt_b <= '0;
      err_cnt    <= '0;
    end else if (cnt_clr) begin
      done_cnt_a <= '0;
      done_cnt_b <= '0;
      err_cnt    <= '0;
    end else if (accept) begin
      if (grant_a && done_cnt_a != CNT_MAX) done_cnt_a <= done_cnt_a + 1'b1;
      if (grant_b && done_cnt_b != CNT_MAX) done_cnt_b <= done_cnt_b + 1'b1;
      if (conv_err && err_cnt != CNT_MAX)   err_cnt    <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_code_conv_sched.sv
// Bench for code_conv_sched: directed steps plus random traffic against a transaction-level
// model; a second instance with 2-bit counters covers saturation.
module tb_code_conv_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid_a = 1'b0, req_mode_a = 1'b0;
  logic       req_valid_b = 1'b0, req_mode_b = 1'b0;
  logic [3:0] req_data_a = 4'd0, req_data_b = 4'd0;
  logic       rsp_ready = 1'b0, cnt_clr = 1'b0;

  logic       req_ready_a, req_ready_b, rsp_valid, rsp_id, rsp_err;
  logic [3:0] rsp_data;
  logic [7:0] done_cnt_a, done_cnt_b, err_cnt;

  logic       s_ready_a, s_ready_b, s_valid, s_id, s_err;
  logic [3:0] s_data;
  logic [1:0] s_done_a, s_done_b, s_err_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  // model state
  logic       m_busy, m_prio, m_id, m_err;
  logic [3:0] m_data;
  int         m_da, m_db, m_de;

  logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  always #5 clk = ~clk;

  code_conv_sched #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_a(req_valid_a), .req_ready_a(req_ready_a), .req_data_a(req_data_a), .req_mode_a(req_mode_a),
    .req_valid_b(req_valid_b), .req_ready_b(req_ready_b), .req_data_b(req_data_b), .req_mode_b(req_mode_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .cnt_clr(cnt_clr), .done_cnt_a(done_cnt_a), .done_cnt_b(done_cnt_b), .err_cnt(err_cnt)
  );

  code_conv_sched #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .req_valid_a(req_valid_a), .req_ready_a(s_ready_a), .req_data_a(req_data_a), .req_mode_a(req_mode_a),
    .req_valid_b(req_valid_b), .req_ready_b(s_ready_b), .req_data_b(req_data_b), .req_mode_b(req_mode_b),
    .rsp_valid(s_valid), .rsp_ready(rsp_ready), .rsp_data(s_data), .rsp_id(s_id), .rsp_err(s_err),
    .cnt_clr(cnt_clr), .done_cnt_a(s_done_a), .done_cnt_b(s_done_b), .err_cnt(s_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cap(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_prio = 1'b0; m_id = 1'b0; m_err = 1'b0; m_data = 4'd0;
    m_da = 0; m_db = 0; m_de = 0;
  endtask

  task automatic check_outputs();
    check("rsp_valid", rsp_valid, m_busy);
    check("rsp_data", rsp_data, m_data);
    check("rsp_id", rsp_id, m_id);
    check("rsp_err", rsp_err, m_err);
    check("done_cnt_a", done_cnt_a, cap(m_da, 255));
    check("done_cnt_b", done_cnt_b, cap(m_db, 255));
    check("err_cnt", err_cnt, cap(m_de, 255));
    check("s_rsp_valid", s_valid, m_busy);
    check("s_done_cnt_a", s_done_a, cap(m_da, 3));
    check("s_done_cnt_b", s_done_b, cap(m_db, 3));
    check("s_err_cnt", s_err_cnt, cap(m_de, 3));
  endtask

  task automatic drive(input logic v_a, input logic [3:0] d_a, input logic md_a,
                       input logic v_b, input logic [3:0] d_b, input logic md_b,
                       input logic rr, input logic clr);
    req_valid_a = v_a; req_data_a = d_a; req_mode_a = md_a;
    req_valid_b = v_b; req_data_b = d_b; req_mode_b = md_b;
    rsp_ready = rr; cnt_clr = clr;
  endtask

  // One clock: check grants mid-cycle, advance the model at the edge, check outputs after it.
  task automatic cycle();
    logic acc, gid;
    logic [3:0] op;
    logic md;
    acc = 1'b0; gid = 1'b0;
    if (!m_busy) begin
      if (req_valid_a && req_valid_b) begin acc = 1'b1; gid = m_prio; end
      else if (req_valid_a) begin acc = 1'b1; gid = 1'b0; end
      else if (req_valid_b) begin acc = 1'b1; gid = 1'b1; end
    end
    @(negedge clk);
    check("req_ready_a", req_ready_a, acc && !gid);
    check("req_ready_b", req_ready_b, acc && gid);
    @(posedge clk);
    if (m_busy) begin
      if (rsp_ready) m_busy = 1'b0;
    end else if (acc) begin
      op = gid ? req_data_b : req_data_a;
      md = gid ? req_mode_b : req_mode_a;
      m_busy = 1'b1; m_id = gid; m_prio = !gid;
      if (md) begin m_data = op ^ (op >> 1); m_err = 1'b0; end
      else if (op <= 4'd9) begin m_data = op + 4'd3; m_err = 1'b0; end
      else begin m_data = 4'd0; m_err = 1'b1; end
    end
    if (cnt_clr) begin
      m_da = 0; m_db = 0; m_de = 0;
    end else if (acc) begin
      if (gid) m_db++; else m_da++;
      if (m_err) m_de++;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] held;
    int accepts;

    // reset state and the basic excess-3 case
    do_reset();
    drive(1, 4'd7, 0, 0, 0, 0, 1, 0);
    cycle();
    check("a7_valid", rsp_valid, 1);
    check("a7_data", rsp_data, 4'b1010);
    check("a7_id", rsp_id, 0);
    check("a7_err", rsp_err, 0);
    check("a7_done_a", done_cnt_a, 1);

    // invalid BCD from B
    drive(0, 0, 0, 1, 4'd13, 0, 1, 0);
    cycle();
    cycle();
    check("b13_data", rsp_data, 0);
    check("b13_err", rsp_err, 1);
    check("b13_err_cnt", err_cnt, 1);
    check("b13_done_b", done_cnt_b, 1);

    // Gray sweep through A
    for (int v = 0; v < 16; v++) begin
      drive(1, 4'(v), 1, 0, 0, 0, 1, 0);
      cycle();
      check("gray", rsp_data, gray_tab[v]);
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      cycle();
    end

    // fairness under continuous contention
    do_reset();
    accepts = 0;
    for (int c = 0; c < 16 && accepts < 8; c++) begin
      drive(1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1, 0);
      cycle();
      if (rsp_valid) begin
        check("rr_id", rsp_id, accepts % 2);
        accepts++;
      end
    end
    check("rr_accepts", accepts, 8);
    check("rr_done_a", done_cnt_a, 4);
    check("rr_done_b", done_cnt_b, 4);

    // back-pressure stall
    drive(1, 4'd4, 0, 0, 0, 0, 0, 0);
    cycle();
    held = rsp_data;
    for (int c = 0; c < 5; c++) begin
      drive(1, 4'd9, 1, 1, 4'd2, 0, 0, 0);
      cycle();
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, held);
      check("stall_ready", {req_ready_a, req_ready_b}, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    cycle();
    check("stall_release", rsp_valid, 0);

    // saturation of the 2-bit instance, then clear
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1, 4'(k), 0, 0, 0, 0, 1, 0);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      cycle();
    end
    check("sat_s_done_a", s_done_a, 3);
    check("sat_done_a", done_cnt_a, 5);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    cycle();
    check("clr_s_done_a", s_done_a, 0);
    check("clr_done_a", done_cnt_a, 0);

    // clear beats a same-cycle increment
    drive(1, 4'd2, 0, 0, 0, 0, 1, 1);
    cycle();
    check("clr_vs_inc", done_cnt_a, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    cycle();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
      cycle();
    end

    // asynchronous reset while holding a result
    drive(0, 0, 0, 1, 4'd5, 1, 0, 0);
    cycle();
    if (!rsp_valid) begin
      drive(0, 0, 0, 1, 4'd5, 1, 0, 0);
      cycle();
    end
    check("pre_arst_valid", rsp_valid, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", rsp_valid, 0);
    check("arst_s_valid", s_valid, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 4'd1, 0, 1, 4'd2, 0, 1, 0);
    cycle();
    check("arst_first_grant", rsp_id, 0);
    check("arst_first_data", rsp_data, 4'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
